fifo16_reader: RTL and testbench
================================

# fifo16_reader

Read-side controller for `fifo16`: issues `rd_en` pops, captures `buf_out` into a 2-entry skid buffer, and presents words downstream on a valid/ready handshake at one word per cycle. Generates a `wr_pause` flow-control flag for the upstream writer from the FIFO `almost_full`/`almost_empty` flags, with hysteresis. Sits between `fifo16` and the consuming datapath; the writer side of `fifo16` is unchanged.

## Interface

**Parameters**
- `DATA_WIDTH`, 4: word width; must match `fifo16`.
- `BUF_WIDTH`, 4: `fifo16` address width; `fifo_counter` is `BUF_WIDTH+1` bits.

**Ports**
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `buf_out` in `DATA_WIDTH`: FIFO read data; updated at the posedge that samples `rd_en=1`.
- `buf_empty` in 1: FIFO empty flag.
- `almost_full` in 1: FIFO occupancy at or above the high threshold.
- `almost_empty` in 1: FIFO occupancy at or below the low threshold.
- `fifo_counter` in `BUF_WIDTH+1`: FIFO occupancy; monitor only, no control use.
- `rd_en` out 1: pop request to FIFO; combinational.
- `data_out` out `DATA_WIDTH`: downstream word; registered skid head.
- `valid_out` out 1: `data_out` valid.
- `ready_in` in 1: downstream accepts the word when `valid_out && ready_in` at posedge.
- `wr_pause` out 1: registered; upstream must not push while high.

## Operation

- State:
  - skid buffer, 2 entries;
  - `skid_cnt` (0..2);
  - `inflight` flag: registered copy of `rd_en`;
  - pause FSM with states RUN and PAUSE.
- `pop_dn` = `valid_out && ready_in`.
- `rd_en = !rst && !buf_empty && (skid_cnt + inflight - pop_dn) < 2`. A read is never issued unless skid space is guaranteed when its data arrives.
- Capture: when `inflight=1` at a posedge, the skid buffer writes `buf_out` at its tail.
- `skid_cnt` next value = `skid_cnt + inflight - pop_dn`.
  - Capture and downstream pop in the same cycle: count unchanged, order preserved.
  - The skid buffer never overflows; overflow is a verification assertion.
- `valid_out = (skid_cnt != 0)`. `data_out` = oldest entry. `data_out` holds stable while `valid_out && !ready_in`.
- Pause FSM:
  - RUN -> PAUSE when `almost_full=1`.
  - PAUSE -> RUN when `almost_empty=1`.
  - If both flags are high at once, PAUSE takes priority from RUN, and PAUSE stays PAUSE.
  - `wr_pause` is 1 in PAUSE.
- Reset values (synchronous): `skid_cnt=0`, `inflight=0`, FSM=RUN, `wr_pause=0`, `valid_out=0`, `data_out=0`, `rd_en=0` while `rst=1`.
- Reset mid-operation:
  - In-flight and buffered words are discarded.
  - FIFO contents are the FIFO's own reset responsibility.
  - After `rst` falls, reading resumes from the first cycle in which `buf_empty=0`.

## Timing

- Read latency:
  - `rd_en=1` in cycle t.
  - FIFO presents `buf_out` after the edge ending cycle t.
  - Captured at the edge ending cycle t+1.
  - `valid_out=1` in cycle t+2.
- Throughput: 1 word/cycle sustained while `buf_empty=0` and `ready_in=1`.
- Backpressure:
  - `ready_in=0` with the skid buffer full: `rd_en=0` next cycle.
  - At most 2 words are buffered.
  - No word is lost or duplicated.
- `buf_empty` reflects the FIFO's registered counter, so `rd_en` never targets an empty FIFO.
- `wr_pause` asserts one cycle after `almost_full` rises and deasserts one cycle after `almost_empty` rises (registered FSM).

## Configuration

- Macro: `FIFO16_READER_CNT_EN`.
- Defined:
  - Adds output `pop_count` [15:0]: number of completed downstream transfers (`pop_dn`).
  - Wraps 16'hFFFF -> 0.
  - Reset to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan

- **Reset and idle:** `rst=1` for 2 cycles, `buf_empty=1` -> `rd_en=0`, `valid_out=0`, `data_out=0`, `wr_pause=0`. After reset with FIFO still empty -> `rd_en` stays 0.
- **Single word:** push 7 into `fifo16`.
  - `rd_en` pulses once.
  - `valid_out=1` with `data_out=7` two cycles later; held until `ready_in=1`, then `valid_out=0`.
- **Streaming order:** push 1..15, `ready_in=1` -> `data_out` sequence 1..15 on consecutive cycles with no gaps after the first word; then `buf_empty=1` and `rd_en=0`.
- **Backpressure:** 8 words queued, `ready_in` low for 5 cycles mid-stream.
  - `skid_cnt` saturates at 2 and `rd_en=0` while stalled.
  - Output sequence is complete and in order after release.
- **Pause hysteresis:** with `uH=2`, `uL=3`, fill until `almost_full=1` -> `wr_pause=1` next cycle. Drain until `almost_empty=1` -> `wr_pause=0` next cycle. No toggle on intermediate occupancy.
- **Reset mid-stream and counter:** assert `rst` with 2 words buffered and 1 in flight -> next cycle `valid_out=0`, `skid_cnt=0`. With `FIFO16_READER_CNT_EN` defined, `pop_count` returns to 0 and then equals the number of accepted words.

Source files
------------

// File: rtl/fifo16_reader_if.sv
// fifo16_reader_if: bus bundle between fifo16, the reader and the consumer.
// master = reader side; slave = environment (FIFO + downstream).
interface fifo16_reader_if #(
  parameter int DATA_WIDTH = 4,
  parameter int BUF_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [BUF_WIDTH:0]    fifo_counter;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;
  logic                  wr_pause;

  modport master (
    input  buf_out,
    input  buf_empty,
    input  almost_full,
    input  almost_empty,
    input  fifo_counter,
    input  ready_in,
    output rd_en,
    output data_out,
    output valid_out,
    output wr_pause
  );

  modport slave (
    output buf_out,
    output buf_empty,
    output almost_full,
    output almost_empty,
    output fifo_counter,
    output ready_in,
    input  rd_en,
    input  data_out,
    input  valid_out,
    input  wr_pause
  );
endinterface

// File: rtl/fifo16_reader.sv
// fifo16_reader: pops fifo16 into a 2-entry skid buffer, valid/ready out.
// Optional FIFO16_READER_CNT_EN adds a 16-bit pop_count output.
module fifo16_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int BUF_WIDTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  fifo16_reader_if.master bus
`ifdef FIFO16_READER_CNT_EN
  ,
  output logic [15:0] pop_count
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } pstate_e;

  logic [DATA_WIDTH-1:0] skid_q [2];
  logic [DATA_WIDTH-1:0] skid_d [2];
  logic                  head_q;
  logic                  head_d;
  logic [1:0]            skid_cnt_q;
  logic [1:0]            skid_cnt_d;
  logic                  inflight_q;
  logic                  inflight_d;

  pstate_e               pstate_q;
  logic                  wr_pause_q;

  logic                  pop_dn;
  logic                  rd_en;
  logic                  tail;
  logic [2:0]            occ;
  logic                  unused_mon;

  assign unused_mon = ^bus.fifo_counter;

  // occ: skid occupancy after this edge, counting the in-flight word
  always_comb begin
    pop_dn = (skid_cnt_q != 2'd0) && bus.ready_in;
    occ    = {1'b0, skid_cnt_q}
           + {2'b00, inflight_q}
           - {2'b00, pop_dn};
    rd_en  = !rst && !bus.buf_empty
           && (occ < 3'd2);
    tail   = head_q ^ skid_cnt_q[0];

    skid_d = skid_q;
    if (inflight_q) begin
      skid_d[tail] = bus.buf_out;
    end
    head_d     = head_q ^ pop_dn;
    skid_cnt_d = occ[1:0];
    inflight_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      head_q     <= 1'b0;
      skid_cnt_q <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      skid_q[0]  <= skid_d[0];
      skid_q[1]  <= skid_d[1];
      head_q     <= head_d;
      skid_cnt_q <= skid_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // PAUSE holds while almost_full is still high
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q   <= RUN;
      wr_pause_q <= 1'b0;
    end else begin
      unique case (pstate_q)
        RUN: begin
          if (bus.almost_full) begin
            pstate_q   <= PAUSE;
            wr_pause_q <= 1'b1;
          end
        end
        PAUSE: begin
          if (bus.almost_empty
              && !bus.almost_full) begin
            pstate_q   <= RUN;
            wr_pause_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef FIFO16_READER_CNT_EN
  logic [15:0] pop_count_q;
  logic [15:0] pop_count_d;

  always_comb begin
    pop_count_d = pop_count_q + {15'd0, pop_dn};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count_q <= 16'd0;
    end else begin
      pop_count_q <= pop_count_d;
    end
  end

  assign pop_count = pop_count_q;
`endif

  assign bus.rd_en     = rd_en;
  assign bus.valid_out = (skid_cnt_q != 2'd0);
  assign bus.data_out  = skid_q[head_q];
  assign bus.wr_pause  = wr_pause_q;

endmodule

// File: tb/tb_fifo16_reader.sv
// tb_fifo16_reader: queue-based fifo16 model, scoreboard and directed plus
// random stimulus for fifo16_reader.
module tb_fifo16_reader;
  localparam int DW = 4;
  localparam int BW = 4;
  localparam int DEPTH = 16;
  localparam int U_H = 2;
  localparam int U_L = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo16_reader_if #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) bus ();

`ifdef FIFO16_READER_CNT_EN
  logic [15:0] pop_count;
`endif

  fifo16_reader #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef FIFO16_READER_CNT_EN
    ,
    .pop_count (pop_count)
`endif
  );

  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int            stamp[$];
  int            cyc = 0;
  int            accepted = 0;
  logic          exp_pause = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fifo16 model, downstream scoreboard and pause reference
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      fq.delete();
      sb.delete();
      accepted = 0;
      exp_pause <= 1'b0;
      bus.buf_out <= '0;
      bus.buf_empty <= 1'b1;
      bus.almost_full <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.fifo_counter <= '0;
    end else begin
      if (bus.valid_out && bus.ready_in) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("data_order", bus.data_out, sb[0]);
          void'(sb.pop_front());
        end
        accepted++;
        stamp.push_back(cyc);
      end
      if (bus.rd_en) begin
        chk("rd_nonempty", fq.size() != 0, 1);
        if (fq.size() != 0) bus.buf_out <= fq.pop_front();
      end
      if (push_en && fq.size() < DEPTH) begin
        fq.push_back(push_data);
        sb.push_back(push_data);
      end
      if (bus.almost_full) exp_pause <= 1'b1;
      else if (bus.almost_empty) exp_pause <= 1'b0;
      bus.buf_empty <= (fq.size() == 0);
      bus.almost_full <= (fq.size() >= DEPTH - U_H);
      bus.almost_empty <= (fq.size() <= U_L);
      bus.fifo_counter <= (BW+1)'(fq.size());
    end
  end

  always @(negedge clk) begin
    chk("wr_pause", bus.wr_pause, exp_pause);
    chk("skid_bound", dut.skid_cnt_q <= 2'd2, 1);
`ifdef FIFO16_READER_CNT_EN
    chk("pop_count", pop_count, 32'(accepted[15:0]));
`endif
  end

  task automatic push(input logic [DW-1:0] d);
    push_en = 1'b1;
    push_data = d;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  initial begin
    bus.ready_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_pause", bus.wr_pause, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rd_en", bus.rd_en, 0);
      chk("idle_valid", bus.valid_out, 0);
    end

    push(4'd7);
    chk("single_rd_en", bus.rd_en, 1);
    @(negedge clk);
    chk("single_rd_once", bus.rd_en, 0);
    chk("single_lat", bus.valid_out, 0);
    @(negedge clk);
    chk("single_valid", bus.valid_out, 1);
    chk("single_data", bus.data_out, 7);
    repeat (3) begin
      @(negedge clk);
      chk("single_hold_v", bus.valid_out, 1);
      chk("single_hold_d", bus.data_out, 7);
    end
    bus.ready_in = 1'b1;
    @(negedge clk);
    chk("single_done", bus.valid_out, 0);

    stamp.delete();
    for (int i = 1; i <= 15; i++) push(4'(i));
    repeat (8) @(negedge clk);
    chk("stream_count", stamp.size(), 15);
    if (stamp.size() == 15)
      for (int i = 1; i < 15; i++)
        chk("stream_gap", stamp[i] - stamp[i-1], 1);
    chk("stream_rd_en", bus.rd_en, 0);
    chk("stream_empty", bus.buf_empty, 1);
    chk("stream_valid", bus.valid_out, 0);

    bus.ready_in = 1'b0;
    for (int i = 0; i < 8; i++) push(4'($urandom));
    bus.ready_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.ready_in = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", bus.valid_out, 1);
      if (sb.size() != 0) chk("bp_hold", bus.data_out, sb[0]);
    end
    chk("bp_skid", dut.skid_cnt_q, 2);
    chk("bp_rd_en", bus.rd_en, 0);
    bus.ready_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("bp_drained", sb.size(), 0);
    chk("bp_idle", bus.valid_out, 0);

    bus.ready_in = 1'b0;
    for (int k = 0; k < 30 && !bus.almost_full; k++)
      push(4'($urandom));
    chk("af_seen", bus.almost_full, 1);
    chk("pause_lag", bus.wr_pause, 0);
    @(negedge clk);
    chk("pause_set", bus.wr_pause, 1);
    bus.ready_in = 1'b1;
    for (int k = 0; k < 40 && !bus.almost_empty; k++) begin
      @(negedge clk);
      chk("pause_hold", bus.wr_pause, 1);
    end
    chk("ae_seen", bus.almost_empty, 1);
    @(negedge clk);
    chk("pause_clear", bus.wr_pause, 0);
    repeat (25) @(negedge clk);
    chk("pause_drained", sb.size(), 0);

    for (int k = 0; k < 1500; k++) begin
      if (k < 750) bus.ready_in = ($urandom_range(0, 3) == 0);
      else bus.ready_in = ($urandom_range(0, 3) != 0);
      push_en = !bus.wr_pause && fq.size() < DEPTH
              && ($urandom_range(0, 3) != 0);
      push_data = 4'($urandom);
      @(negedge clk);
    end
    push_en = 1'b0;
    bus.ready_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("rand_drained", sb.size(), 0);
    chk("rand_idle", bus.valid_out, 0);

    for (int i = 1; i <= 4; i++) push(4'(i));
    chk("mid_pre_valid", bus.valid_out, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valid", bus.valid_out, 0);
    chk("mid_skid", dut.skid_cnt_q, 0);
    chk("mid_rd_en", bus.rd_en, 0);
`ifdef FIFO16_READER_CNT_EN
    chk("mid_pop_count", pop_count, 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push(4'(i + 9));
    repeat (8) @(negedge clk);
    chk("post_rst_count", accepted, 5);
`ifdef FIFO16_READER_CNT_EN
    chk("post_pop_count", pop_count, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
